prog_loader: RTL and testbench

//  Byte-stream program loader: writer side of program memory, whose words the instruction decoder reads.

---
 rtl/prog_loader.sv | 203 ++++++++++++++++++++
 tb/tb_prog_loader.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// Byte-stream program loader.
// Accepts a framed byte stream (COUNT, N x {HI, LO}, CSUM) over a valid/ready
// link, packs HI/LO pairs into instruction words, writes them to program
// memory from address 0 upward and verifies an 8-bit additive checksum.
// The CPU is held at PC 0 while a load runs and after a failed load.
//
// Handshake: a byte moves on a rising clk edge only when byteValid and
// byteReady are both 1; byteReady depends only on the current state, never on
// byteValid, and the loader never takes a byte it did not signal ready for.
module prog_loader #(
    parameter int prog_mem_length = 8,
    parameter int prog_mem_width  = 13
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [7:0]                 byteIn,
    input  logic                       byteValid,
    output logic                       byteReady,
    output logic                       wrPm,
    output logic [prog_mem_length-1:0] adrPm,
    output logic [prog_mem_width-1:0]  dataPm,
    output logic                       holdCpu,
    output logic                       busy,
    output logic                       done,
    output logic                       err,
    output logic [2:0]                 dbgState
);

    // Number of word bits carried in the HI byte.
    localparam int HI_BITS = prog_mem_width - 8;
    // Remaining-word counter needs one extra bit to hold the full 2**L count.
    localparam int REM_W = prog_mem_length + 1;
    localparam logic [REM_W-1:0] REM_FULL = {1'b1, {prog_mem_length{1'b0}}};
    localparam logic [REM_W-1:0] REM_ONE  = {{(REM_W-1){1'b0}}, 1'b1};
    // HI byte bits that lie above the instruction width and must be zero.
    localparam logic [15:0] HI_MASK_WIDE = 16'h00FF << HI_BITS;
    localparam logic [7:0]  HI_UNUSED    = HI_MASK_WIDE[7:0];

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        COUNT = 3'd1,
        HI    = 3'd2,
        LO    = 3'd3,
        WRITE = 3'd4,
        CSUM  = 3'd5,
        DONE  = 3'd6,
        ERR   = 3'd7
    } stateT;

    stateT                      state;
    stateT                      stateNext;
    logic                       xfer;
    logic                       loadStart;
    logic [prog_mem_length-1:0] adr;
    logic [REM_W-1:0]           remaining;
    logic [REM_W-1:0]           countWords;
    logic [7:0]                 sum;
    logic [HI_BITS-1:0]         hiReg;
    logic [prog_mem_width-1:0]  word;

    assign xfer       = byteValid & byteReady;
    // A COUNT byte of zero stands for a full memory image.
    assign countWords = (byteIn == 8'd0) ? REM_FULL : REM_W'(byteIn);

    assign adrPm    = adr;
    assign dataPm   = word;
    assign dbgState = state;

    // State register; reset aborts any load in progress.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state decode and all state-derived outputs.
    always_comb begin
        stateNext = state;
        byteReady = 1'b0;
        wrPm      = 1'b0;
        busy      = 1'b0;
        holdCpu   = 1'b1;
        done      = 1'b0;
        err       = 1'b0;
        loadStart = 1'b0;
        unique case (state)
            IDLE: begin
                holdCpu = 1'b0;
                if (start) begin
                    loadStart = 1'b1;
                    stateNext = COUNT;
                end
            end
            COUNT: begin
                busy      = 1'b1;
                byteReady = 1'b1;
                if (byteValid) begin
                    stateNext = HI;
                end
            end
            HI: begin
                busy      = 1'b1;
                byteReady = 1'b1;
                if (byteValid) begin
                    // Any set bit above the instruction width is a framing error.
                    stateNext = ((byteIn & HI_UNUSED) != 8'd0) ? ERR : LO;
                end
            end
            LO: begin
                busy      = 1'b1;
                byteReady = 1'b1;
                if (byteValid) begin
                    stateNext = WRITE;
                end
            end
            WRITE: begin
                busy      = 1'b1;
                wrPm      = 1'b1;
                stateNext = (remaining == REM_ONE) ? CSUM : HI;
            end
            CSUM: begin
                busy      = 1'b1;
                byteReady = 1'b1;
                if (byteValid) begin
                    stateNext = (byteIn == sum) ? DONE : ERR;
                end
            end
            DONE: begin
                holdCpu = 1'b0;
                done    = 1'b1;
                if (start) begin
                    loadStart = 1'b1;
                    stateNext = COUNT;
                end
            end
            ERR: begin
                err = 1'b1;
                if (start) begin
                    loadStart = 1'b1;
                    stateNext = COUNT;
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // Write address: cleared on a new load, advances after each write pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            adr <= '0;
        end else if (loadStart) begin
            adr <= '0;
        end else if (state == WRITE) begin
            adr <= adr + 1'b1;
        end
    end

    // Words still to be written in this load.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            remaining <= '0;
        end else if (loadStart) begin
            remaining <= '0;
        end else if (state == COUNT && xfer) begin
            remaining <= countWords;
        end else if (state == WRITE) begin
            remaining <= remaining - REM_ONE;
        end
    end

    // Running mod-256 sum over COUNT, HI and LO bytes; CSUM byte is excluded.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum <= 8'd0;
        end else if (loadStart) begin
            sum <= 8'd0;
        end else if (xfer && (state == COUNT || state == HI || state == LO)) begin
            sum <= sum + byteIn;
        end
    end

    // Word assembly: HI bits held until LO arrives, then the full word is
    // latched and kept stable through the WRITE cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hiReg <= '0;
            word  <= '0;
        end else begin
            if (state == HI && xfer) begin
                hiReg <= byteIn[HI_BITS-1:0];
            end
            if (state == LO && xfer) begin
                word <= {hiReg, byteIn};
            end
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: random framed loads checked against a
// stream-level reference model (expected writes queue plus final outcome).
module tb_prog_loader;

    localparam int L = 8;
    localparam int W = 13;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [7:0]   byteIn = 8'd0;
    logic         byteValid = 1'b0;
    logic         byteReady;
    logic         wrPm;
    logic [L-1:0] adrPm;
    logic [W-1:0] dataPm;
    logic         holdCpu;
    logic         busy;
    logic         done;
    logic         err;
    logic [2:0]   dbgState;

    prog_loader #(.prog_mem_length(L), .prog_mem_width(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .byteIn(byteIn), .byteValid(byteValid), .byteReady(byteReady),
        .wrPm(wrPm), .adrPm(adrPm), .dataPm(dataPm),
        .holdCpu(holdCpu), .busy(busy), .done(done), .err(err),
        .dbgState(dbgState)
    );

    // Clock
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [L+W-1:0] expQ[$];
    logic [W-1:0]   words[256];
    logic [L+W-1:0] monE;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every write pulse must match the next expected {adr, data}.
    always @(negedge clk) begin
        if (rst_n && wrPm) begin
            check("ready_low_in_write", 32'(byteReady), 32'd0);
            check("write_expected", 32'(expQ.size() != 0), 32'd1);
            if (expQ.size() != 0) begin
                monE = expQ.pop_front();
                check("write_adr", 32'(adrPm), 32'(monE[L+W-1:W]));
                check("write_data", 32'(dataPm), 32'(monE[W-1:0]));
            end
        end
    end

    // Watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    // Driver: offer one byte after a random gap and wait for acceptance.
    task automatic sendByte(input logic [7:0] b, input int maxGap);
        int gap;
        int waitCnt;
        gap = (maxGap > 0) ? $urandom_range(0, maxGap) : 0;
        byteValid = 1'b0;
        repeat (gap) @(negedge clk);
        byteValid = 1'b1;
        byteIn    = b;
        waitCnt   = 0;
        while (!byteReady && waitCnt < 50) begin
            @(negedge clk);
            waitCnt++;
        end
        check("byte_accepted", 32'(byteReady), 32'd1);
        @(negedge clk);
        byteValid = 1'b0;
    endtask

    task automatic pulseStart();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // One load: mode 0 good, 1 bad checksum, 2 bad HI at word errIdx.
    task automatic runLoad(input string name, input int n, input int mode,
                           input int errIdx, input int maxGap);
        logic [7:0] cnt;
        logic [7:0] sum;
        logic [7:0] hi;
        logic [7:0] lo;
        bit aborted;
        aborted = 1'b0;
        expQ.delete();
        cnt = 8'(n);
        sum = cnt;
        pulseStart();
        check({name, "_busy_start"}, 32'(busy), 32'd1);
        check({name, "_hold_start"}, 32'(holdCpu), 32'd1);
        check({name, "_done_clear"}, 32'(done), 32'd0);
        check({name, "_err_clear"}, 32'(err), 32'd0);
        sendByte(cnt, maxGap);
        // start while busy must be ignored
        pulseStart();
        check({name, "_busy_ignore_start"}, 32'(busy), 32'd1);
        for (int i = 0; i < n; i++) begin
            hi = 8'(words[i] >> 8);
            lo = words[i][7:0];
            if (mode == 2 && i == errIdx) begin
                hi = hi | (8'h20 << (errIdx % 3));
                sendByte(hi, maxGap);
                aborted = 1'b1;
                break;
            end
            expQ.push_back({L'(i), words[i]});
            sum = 8'(sum + hi + lo);
            sendByte(hi, maxGap);
            sendByte(lo, maxGap);
        end
        if (!aborted) begin
            sendByte((mode == 1) ? 8'(sum + 8'd1) : sum, maxGap);
        end
        repeat (2) @(negedge clk);
        check({name, "_done"}, 32'(done), (mode == 0) ? 32'd1 : 32'd0);
        check({name, "_err"}, 32'(err), (mode == 0) ? 32'd0 : 32'd1);
        check({name, "_hold"}, 32'(holdCpu), (mode == 0) ? 32'd0 : 32'd1);
        check({name, "_busy_end"}, 32'(busy), 32'd0);
        check({name, "_ready_end"}, 32'(byteReady), 32'd0);
        check({name, "_writes_left"}, 32'(expQ.size()), 32'd0);
    endtask

    initial begin
        // Reset
        repeat (3) @(negedge clk);
        check("rst_wrPm", 32'(wrPm), 32'd0);
        check("rst_hold", 32'(holdCpu), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done_err", 32'({done, err}), 32'd0);
        check("rst_adr_data", 32'({adrPm, dataPm}), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // T2: two-word load 02,1F,FF,00,2A,4A
        words[0] = 13'h1FFF;
        words[1] = 13'h002A;
        runLoad("t2", 2, 0, 0, 0);
        // bytes offered in DONE are not taken
        byteValid = 1'b1;
        byteIn    = 8'h55;
        repeat (3) begin
            @(negedge clk);
            check("done_no_accept", 32'(byteReady), 32'd0);
            check("done_sticky", 32'(done), 32'd1);
        end
        byteValid = 1'b0;

        // T3: bad checksum (4B)
        runLoad("t3", 2, 1, 0, 0);

        // T4: format error, N=1, HI=0x20
        words[0] = 13'h0000;
        runLoad("t4", 1, 2, 0, 0);

        // T5: T2 data with random gaps
        words[0] = 13'h1FFF;
        words[1] = 13'h002A;
        runLoad("t5", 2, 0, 0, 3);

        // T1: reset mid-LO aborts without writing
        expQ.delete();
        pulseStart();
        sendByte(8'd1, 0);
        sendByte(8'h01, 0);
        byteValid = 1'b1;
        byteIn    = 8'h23;
        rst_n     = 1'b0;
        @(negedge clk);
        byteValid = 1'b0;
        check("t1_wrPm", 32'(wrPm), 32'd0);
        check("t1_hold", 32'(holdCpu), 32'd0);
        check("t1_ready", 32'(byteReady), 32'd0);
        check("t1_done_err", 32'({done, err}), 32'd0);
        check("t1_busy", 32'(busy), 32'd0);
        // start in the same cycle as reset: reset wins
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("t1_start_in_reset", 32'(busy), 32'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("t1_idle_after", 32'({busy, holdCpu}), 32'd0);

        // Random loads
        for (int k = 0; k < 8; k++) begin
            int n;
            int mode;
            n    = $urandom_range(1, 12);
            mode = $urandom_range(0, 2);
            for (int i = 0; i < n; i++) begin
                words[i] = W'($urandom_range(0, (1 << W) - 1));
            end
            runLoad($sformatf("rnd%0d", k), n, mode, $urandom_range(0, n - 1),
                    $urandom_range(0, 3));
        end

        // T6: full 256-word load, data = address
        for (int i = 0; i < 256; i++) begin
            words[i] = W'(i);
        end
        runLoad("t6", 256, 0, 0, 0);
        repeat (4) @(negedge clk);
        check("t6_no_rollover", 32'(expQ.size()), 32'd0);

        // start from DONE restarts cleanly
        words[0] = 13'h1FFF;
        words[1] = 13'h002A;
        runLoad("restart", 2, 0, 0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
